// File: rtl/rstatus_pkg.sv
// Shared constants and types for the overflow-status event reader.
package rstatus_pkg;

  localparam logic [4:0] STATUS_REG_ID = 5'd30;

  localparam logic [31:0] CODE_ADD_OVF  = 32'd1;
  localparam logic [31:0] CODE_ADDI_OVF = 32'd2;
  localparam logic [31:0] CODE_SUB_OVF  = 32'd3;

  typedef enum logic [1:0] {
    EVT_ADD  = 2'd0,
    EVT_ADDI = 2'd1,
    EVT_SUB  = 2'd2,
    EVT_UNK  = 2'd3
  } evt_code_e;

  typedef struct packed {
    evt_code_e   code;
    logic [31:0] raw;
  } evt_entry_t;

endpackage

// File: rtl/rstatus_fifo.sv
// Synchronous FIFO of decoded status events; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module rstatus_fifo
  import rstatus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  evt_entry_t wdata,
  output evt_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  evt_entry_t            mem_q [DEPTH];
  logic       [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic       [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic       [CntW-1:0] count_q, count_d;
  logic                  pop_eff, push_eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  // Empty head reads as zero so evt_code/evt_raw stay at their reset values.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_eff  = pop && !empty;
    push_eff = push && (!full || pop_eff);
    wr_ptr_d = push_eff ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_eff ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push_eff) - CntW'(pop_eff);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_eff) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/rstatus_event_reader.sv
// Snoops register writeback for status-register exception codes, queues them and
// keeps saturating per-code and drop counters. RSTATUS_STRICT_EN adds unknown-code capture.
module rstatus_event_reader
  import rstatus_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 16,
  parameter logic [4:0]  STATUS_REG = STATUS_REG_ID
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [31:0]      evt_raw,
  output logic             fifo_full,
  output logic [CNT_W-1:0] cnt_add,
  output logic [CNT_W-1:0] cnt_addi,
  output logic [CNT_W-1:0] cnt_sub,
`ifdef RSTATUS_STRICT_EN
  output logic [CNT_W-1:0] unk_count,
`endif
  output logic [CNT_W-1:0] drop_count,
  input  logic             clear_counts
);

`ifdef RSTATUS_STRICT_EN
  localparam int unsigned NumCodes = 4;
`else
  localparam int unsigned NumCodes = 3;
`endif

  logic       capture;
  evt_code_e  code;
  evt_entry_t head;
  logic       fifo_empty;
  logic       pop;
  logic       drop;

  logic [CNT_W-1:0] cnt_q [NumCodes];
  logic [CNT_W-1:0] cnt_d [NumCodes];
  logic [CNT_W-1:0] drop_q, drop_d;

  // Clear takes effect before the increment, so clear+event yields 1.
  function automatic logic [CNT_W-1:0] sat_next(logic [CNT_W-1:0] cur, logic clr, logic inc);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cur;
    return (inc && (base != '1)) ? base + CNT_W'(1) : base;
  endfunction

  always_comb begin
    capture = 1'b0;
    code    = EVT_ADD;
    if (wb_we && (wb_reg == STATUS_REG)) begin
      case (wb_data)
        CODE_ADD_OVF:  begin capture = 1'b1; code = EVT_ADD;  end
        CODE_ADDI_OVF: begin capture = 1'b1; code = EVT_ADDI; end
        CODE_SUB_OVF:  begin capture = 1'b1; code = EVT_SUB;  end
        default: begin
`ifdef RSTATUS_STRICT_EN
          if (wb_data != '0) begin
            capture = 1'b1;
            code    = EVT_UNK;
          end
`endif
        end
      endcase
    end
  end

  assign pop  = evt_valid && evt_ready;
  assign drop = capture && fifo_full && !pop;

  rstatus_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (capture),
    .pop  (evt_ready),
    .wdata('{code: code, raw: wb_data}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_raw   = head.raw;

  always_comb begin
    for (int i = 0; i < NumCodes; i++) begin
      cnt_d[i] = sat_next(cnt_q[i], clear_counts, capture && (code == evt_code_e'(i)));
    end
    drop_d = sat_next(drop_q, clear_counts, drop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumCodes; i++) cnt_q[i] <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < NumCodes; i++) cnt_q[i] <= cnt_d[i];
      drop_q <= drop_d;
    end
  end

  assign cnt_add    = cnt_q[EVT_ADD];
  assign cnt_addi   = cnt_q[EVT_ADDI];
  assign cnt_sub    = cnt_q[EVT_SUB];
`ifdef RSTATUS_STRICT_EN
  assign unk_count  = cnt_q[EVT_UNK];
`endif
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rstatus_event_reader.sv
// Directed self-checking bench for rstatus_event_reader (counters narrowed to 4 bits).
module tb_rstatus_event_reader;

  localparam int unsigned CntW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            wb_we = 1'b0;
  logic [4:0]      wb_reg = '0;
  logic [31:0]     wb_data = '0;
  logic            evt_valid;
  logic            evt_ready = 1'b0;
  logic [1:0]      evt_code;
  logic [31:0]     evt_raw;
  logic            fifo_full;
  logic [CntW-1:0] cnt_add, cnt_addi, cnt_sub, drop_count;
`ifdef RSTATUS_STRICT_EN
  logic [CntW-1:0] unk_count;
`endif
  logic            clear_counts = 1'b0;

  int checks = 0;
  int fails  = 0;

  rstatus_event_reader #(
    .DEPTH(4),
    .CNT_W(CntW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wb_we       (wb_we),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_raw     (evt_raw),
    .fifo_full   (fifo_full),
    .cnt_add     (cnt_add),
    .cnt_addi    (cnt_addi),
    .cnt_sub     (cnt_sub),
`ifdef RSTATUS_STRICT_EN
    .unk_count   (unk_count),
`endif
    .drop_count  (drop_count),
    .clear_counts(clear_counts)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wb_we = 1'b1; wb_reg = r; wb_data = d;
  endtask

  task automatic head(input string tag, input logic v, input logic [1:0] c, input logic [31:0] raw);
    check({tag, ".valid"}, 32'(evt_valid), 32'(v));
    check({tag, ".code"}, 32'(evt_code), 32'(c));
    check({tag, ".raw"}, evt_raw, raw);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    head("rst", 1'b0, 2'd0, 32'd0);
    check("rst.full", 32'(fifo_full), 0);
    check("rst.add", 32'(cnt_add), 0);
    check("rst.drop", 32'(drop_count), 0);
    reset = 1'b0;
    tick();

    // Single addi event, then pop
    wr(5'd30, 32'd2); tick(); wb_we = 1'b0;
    head("addi", 1'b1, 2'd1, 32'd2);
    check("addi.cnt", 32'(cnt_addi), 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("addi.popped", 32'(evt_valid), 0);

    // Ordering: add, sub, add
    wr(5'd30, 32'd1); tick();
    wr(5'd30, 32'd3); tick();
    wr(5'd30, 32'd1); tick();
    wb_we = 1'b0;
    head("ord0", 1'b1, 2'd0, 32'd1);
    evt_ready = 1'b1; tick();
    head("ord1", 1'b1, 2'd2, 32'd3);
    tick();
    head("ord2", 1'b1, 2'd0, 32'd1);
    tick(); evt_ready = 1'b0;
    check("ord.empty", 32'(evt_valid), 0);
    check("ord.add", 32'(cnt_add), 2);
    check("ord.sub", 32'(cnt_sub), 1);

    // Five captures into DEPTH=4: last one dropped
    wr(5'd30, 32'd1); tick();
    wr(5'd30, 32'd2); tick();
    wr(5'd30, 32'd3); tick();
    wr(5'd30, 32'd1); tick();
    check("full.flag", 32'(fifo_full), 1);
    wr(5'd30, 32'd2); tick();
    wb_we = 1'b0;
    check("full.drop", 32'(drop_count), 1);
    check("full.add", 32'(cnt_add), 4);
    check("full.addi", 32'(cnt_addi), 3);
    head("full.head", 1'b1, 2'd0, 32'd1);
    // Push and pop together while full
    wr(5'd30, 32'd3); evt_ready = 1'b1; tick(); wb_we = 1'b0;
    check("pp.full", 32'(fifo_full), 1);
    check("pp.drop", 32'(drop_count), 1);
    check("pp.sub", 32'(cnt_sub), 3);
    head("pp.h0", 1'b1, 2'd1, 32'd2);
    tick(); head("pp.h1", 1'b1, 2'd2, 32'd3);
    tick(); head("pp.h2", 1'b1, 2'd0, 32'd1);
    tick(); head("pp.h3", 1'b1, 2'd2, 32'd3);
    tick(); evt_ready = 1'b0;
    head("pp.empty", 1'b0, 2'd0, 32'd0);

    // Clear together with a sub capture
    wr(5'd30, 32'd3); clear_counts = 1'b1; tick();
    wb_we = 1'b0; clear_counts = 1'b0;
    check("clr.sub", 32'(cnt_sub), 1);
    check("clr.add", 32'(cnt_add), 0);
    check("clr.addi", 32'(cnt_addi), 0);
    check("clr.drop", 32'(drop_count), 0);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // Ignored writes
    wr(5'd30, 32'd0); tick();
    wr(5'd5, 32'd1); tick();
    wr(5'd0, 32'd1); tick();
    wb_reg = 5'd30; wb_data = 32'd1; wb_we = 1'b0; tick();
    check("ign.valid", 32'(evt_valid), 0);
    check("ign.add", 32'(cnt_add), 0);
    check("ign.sub", 32'(cnt_sub), 1);

    // Saturation: 17 add events with continuous draining
    evt_ready = 1'b1;
    wr(5'd30, 32'd1);
    for (int i = 0; i < 17; i++) tick();
    wb_we = 1'b0;
    check("sat.add", 32'(cnt_add), 15);
    check("sat.drop", 32'(drop_count), 0);
    tick(); evt_ready = 1'b0;
    check("sat.empty", 32'(evt_valid), 0);

    // Asynchronous reset with 3 events queued
    wr(5'd30, 32'd1); tick();
    wr(5'd30, 32'd2); tick();
    wr(5'd30, 32'd3); tick();
    wb_we = 1'b0;
    check("ar.pre", 32'(evt_valid), 1);
    #2 reset = 1'b1;
    #1;
    head("ar", 1'b0, 2'd0, 32'd0);
    check("ar.add", 32'(cnt_add), 0);
    tick(); reset = 1'b0; tick();

    // Unknown nonzero code
    wr(5'd30, 32'd7); tick(); wb_we = 1'b0;
`ifdef RSTATUS_STRICT_EN
    head("unk", 1'b1, 2'd3, 32'd7);
    check("unk.cnt", 32'(unk_count), 1);
`else
    check("unk.none", 32'(evt_valid), 0);
    check("unk.cnt", 32'(cnt_add + cnt_addi + cnt_sub), 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
